// File: rtl/gf4_mul_arbiter.sv
// Shares one GF(2^4) multiplier (x^4+x+1) among NUM_REQ valid/ready requesters, one grant per cycle.
// Define GF4_MUL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.

module mul_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);
    logic [3:0] acc;
    logic [3:0] sh;

    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            // multiply by x, folding x^4 back in as x+1
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'b0011 : 4'b0000);
        end
    end

    assign p = acc;
endmodule

module gf4_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_d1,
    input  logic [4*NUM_REQ-1:0]   req_d2,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_data,
    output logic [ID_W-1:0]        rsp_id
);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0][3:0] d1_arr;
    logic [NUM_REQ-1:0][3:0] d2_arr;
    logic                    accept_ok;
    logic                    accept;
    logic                    grant_found;
    logic [ID_W-1:0]         grant_idx;
    logic [3:0]              mul_p;

    assign d1_arr = req_d1;
    assign d2_arr = req_d2;

`ifdef GF4_MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end
`else
    localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   rr_sum;

    // walk requesters starting at ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (rr_sum >= NR) rr_sum = rr_sum - NR;
            if (!grant_found && req_valid[rr_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_sum[ID_W-1:0];
            end
        end
    end
`endif

    assign accept_ok = !rsp_valid || rsp_ready;
    assign accept    = grant_found && accept_ok && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    mul_core u_mul (
        .a (d1_arr[grant_idx]),
        .b (d2_arr[grant_idx]),
        .p (mul_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
`ifndef GF4_MUL_ARB_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mul_p;
            rsp_id    <= grant_idx;
`ifndef GF4_MUL_ARB_FIXED_PRIO_EN
            ptr       <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
`endif
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gf4_mul_arbiter.sv
// Randomized and directed bench for gf4_mul_arbiter against a behavioural arbiter/GF(2^4) model.
module tb_gf4_mul_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [4*N-1:0]    req_d1 = '0;
    logic [4*N-1:0]    req_d2 = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [3:0]        rsp_data;
    logic [IW-1:0]     rsp_id;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    gf4_mul_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_d1    (req_d1),
        .req_d2    (req_d2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    // polynomial product then reduction by x^4+x+1 from the top term down
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'(5'b10011) << (i - 4));
        return p[3:0];
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) if (v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    logic       m_valid = 1'b0;
    logic [3:0] m_data  = '0;
    int         m_id    = 0;
    int         m_ptr   = 0;
    int         m_grant;
    logic       m_ok;

`ifdef GF4_MUL_ARB_FIXED_PRIO_EN
    always_comb m_grant = model_grant(req_valid, 0);
`else
    always_comb m_grant = model_grant(req_valid, m_ptr);
`endif
    assign m_ok = !m_valid || rsp_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= 0;
            m_ptr   <= 0;
        end else if (m_grant >= 0 && m_ok) begin
            m_valid <= 1'b1;
            m_data  <= gf_mul(req_d1[4*m_grant +: 4], req_d2[4*m_grant +: 4]);
            m_id    <= m_grant;
            m_ptr   <= (m_grant + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    function automatic logic [N-1:0] exp_ready();
        if (rst || m_grant < 0 || !m_ok) return '0;
        return N'(1) << m_grant;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model req_ready", 32'(req_ready), 32'(exp_ready()));
            chk("model rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("model rsp_data",  32'(rsp_data),  32'(m_data));
            chk("model rsp_id",    32'(rsp_id),    32'(m_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_d1[4*i +: 4] = a;
        req_d2[4*i +: 4] = b;
    endtask

    logic [3:0] c_a [3] = '{4'h3, 4'h0, 4'h1};
    logic [3:0] c_b [3] = '{4'h7, 4'hF, 4'hB};
    logic [3:0] c_p [3] = '{4'h9, 4'h0, 4'hB};
    int         rr_id [6]   = '{0, 1, 2, 3, 0, 1};
    logic [3:0] rr_dat [6]  = '{4'h3, 4'h6, 4'h5, 4'hC, 4'h3, 4'h6};

    initial begin
        rst = 1'b1;
        req_valid = '1;
        tick();
        tick();
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_data",  32'(rsp_data),  32'h0);
        chk("reset rsp_id",    32'(rsp_id),    32'h0);
        rst = 1'b0;
        req_valid = '0;
        cmp_en = 1'b1;

        // single request from requester 1
        req_valid = 4'b0010;
        set_op(1, 4'h2, 4'h8);
        #3;
        chk("single req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("single rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single rsp_data",  32'(rsp_data),  32'h3);
        chk("single rsp_id",    32'(rsp_id),    32'h1);

        // arithmetic corners and full sweep through requester 0
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            set_op(0, c_a[i], c_b[i]);
            tick();
            chk("corner rsp_data", 32'(rsp_data), 32'(c_p[i]));
        end
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_op(0, 4'(a), 4'(b));
                tick();
                chk("sweep rsp_data", 32'(rsp_data), 32'(gf_mul(4'(a), 4'(b))));
            end
        end
        req_valid = '0;

`ifndef GF4_MUL_ARB_FIXED_PRIO_EN
        // bring ptr to 0 via requester 3, then round-robin over all four
        req_valid = 4'b1000;
        tick();
        for (int i = 0; i < N; i++) set_op(i, 4'(i + 1), 4'h3);
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr rsp_id",    32'(rsp_id),    32'(rr_id[i]));
            chk("rr rsp_data",  32'(rsp_data),  32'(rr_dat[i]));
            chk("rr rsp_valid", 32'(rsp_valid), 32'h1);
        end

        // backpressure holding requester 1's product, ptr at 2
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("bp req_ready", 32'(req_ready), 32'h0);
            tick();
            chk("bp rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp rsp_id",    32'(rsp_id),    32'h1);
            chk("bp rsp_data",  32'(rsp_data),  32'h6);
        end
        rsp_ready = 1'b1;
        #3;
        chk("bp release req_ready", 32'(req_ready), 32'h4);
        tick();
        chk("bp release rsp_id",   32'(rsp_id),   32'h2);
        chk("bp release rsp_data", 32'(rsp_data), 32'h5);

        // reset mid-response with ptr=2
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async rst rsp_data",  32'(rsp_data),  32'h0);
        chk("async rst rsp_id",    32'(rsp_id),    32'h0);
        chk("async rst req_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        tick();
        chk("post rst rsp_id",    32'(rsp_id),    32'h0);
        chk("post rst rsp_valid", 32'(rsp_valid), 32'h1);
`else
        for (int i = 0; i < N; i++) set_op(i, 4'(i + 1), 4'h3);
        req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fixed rsp_id", 32'(rsp_id), 32'h0);
        end
        req_valid = 4'b1000;
        tick();
        chk("fixed drop rsp_id", 32'(rsp_id), 32'h3);
`endif

        // randomized traffic, checked every cycle by the model compare process
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            req_d1    = 16'($urandom);
            req_d2    = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gf4_mul_arbiter.md
Name: gf4_mul_arbiter

Overview:
Shares one GF(2^4) multiplier core (`mul_core`, field polynomial x^4+x+1) among NUM_REQ requesters, for example time-multiplexed S-box inversion units. Each requester has a valid/ready operand channel. A round-robin arbiter grants one request per cycle. The product is registered and returned on a single shared response channel, tagged with the requester ID. The block sits between S-box sequencing logic and the multiplier datapath, replacing per-unit multiplier instances.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of the requester ID; must equal clog2(NUM_REQ), minimum 1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  bit i: requester i presents operands
req_ready  output  NUM_REQ  bit i: requester i's operands accepted this cycle
req_d1  input  4*NUM_REQ  operand 1; requester i uses bits [4i+3:4i]
req_d2  input  4*NUM_REQ  operand 2; requester i uses bits [4i+3:4i]
rsp_valid  output  1  response register holds a valid product
rsp_ready  input  1  consumer accepts the response
rsp_data  output  4  GF(2^4) product d1*d2
rsp_id  output  ID_W  index of the requester that owns rsp_data

Behaviour:
- Reset (async, immediate, any cycle including mid-response):
  - rsp_valid=0, rsp_data=0, rsp_id=0, round-robin pointer ptr=0.
  - req_ready is all 0 while rst is high.
- Internal accept condition: accept_ok = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Search req_valid starting at index ptr, incrementing modulo NUM_REQ.
  - The first set bit is the grant g.
  - If no bit is set, there is no grant.
- req_ready:
  - req_ready[g] = accept_ok when a grant exists. All other bits are 0.
  - req_ready may depend combinationally on req_valid.
  - req_valid must not depend combinationally on req_ready.
- Accept (req_valid[g] && req_ready[g]) at edge k:
  - rsp_data <= mul_core(d1_g, d2_g); rsp_id <= g; rsp_valid <= 1; ptr <= (g+1) mod NUM_REQ.
  - Latency is 1 cycle: the product is visible in the cycle after the accept.
- No accept, and rsp_valid && rsp_ready: rsp_valid <= 0. rsp_data and rsp_id hold their values (not cleared).
- Backpressure (rsp_valid && !rsp_ready):
  - rsp_valid, rsp_data and rsp_id are held.
  - req_ready is all 0.
  - ptr is unchanged.
- Simultaneous response drain and new accept in the same cycle: the register reloads with the new product and rsp_valid stays 1. This gives a throughput of 1 product per cycle.
- ptr advances only on an accept. Idle cycles do not move it.
- A requester that drops req_valid before acceptance loses nothing. Operands are only sampled on the accept edge.
- Multiplier: the block instantiates a single mul_core. Its inputs are muxed from the granted requester.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NUM_REQ-1,0,... and each requester is starved for at most NUM_REQ-1 accepts.

Optional Feature:
GF4_MUL_ARB_FIXED_PRIO_EN
- Defined: fixed priority. The lowest-index valid requester always wins, ptr is not implemented, and all other behaviour is identical.
- Undefined (default): round-robin arbitration as described above.

Test Plan:
1. Single request: req_valid=0b0010, d1=0x2, d2=0x8 → req_ready=0b0010 that cycle. Next cycle: rsp_valid=1, rsp_data=0x3, rsp_id=1.
2. Arithmetic corners via requester 0 (each → rsp_data):
   - 0x3*0x7 → 0x9
   - 0x0*0xF → 0x0
   - 0x1*0xB → 0xB
   - Then sweep all 256 operand pairs against the golden mul_core.
3. Round-robin: all 4 valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, rsp_valid continuously 1.
4. Backpressure: after an accept, hold rsp_ready=0 for 3 cycles with req_valid=0b1111:
   - req_ready=0, rsp_data and rsp_id stable, rsp_valid=1.
   - Raise rsp_ready → the next grant is ptr's requester and the new product appears the following cycle.
5. Reset mid-operation: assert rst while rsp_valid=1 and ptr=2 → rsp_valid=0 with no clock edge. After release with req_valid=0b1111, the first rsp_id is 0.
6. With GF4_MUL_ARB_FIXED_PRIO_EN defined: req_valid=0b1001 continuous → rsp_id=0 every cycle. Drop req 0 → rsp_id=3.
